// File: rtl/control_captura_pkg.sv
// Shared constants for the two-operand keypad capture controller.
package control_captura_pkg;

    localparam int ANCHO_NUM_DEF = 7;

    localparam logic [3:0] TECLA_SIG   = 4'hA;
    localparam logic [3:0] TECLA_ENTER = 4'hE;
    localparam logic [3:0] TECLA_CLR   = 4'hC;

    typedef logic [1:0] estado_t;

    localparam estado_t CAP_DEC   = 2'd0;
    localparam estado_t CAP_UNI   = 2'd1;
    localparam estado_t CAP_LLENO = 2'd2;
    localparam estado_t ESPERA_OP = 2'd3;

endpackage

// File: rtl/control_captura_operandos_bcd2_a_bin.sv
// Two BCD digits (tens, units) to binary: dec*10 + uni.
module bcd2_a_bin
    import control_captura_pkg::*;
#(
    parameter int ANCHO = ANCHO_NUM_DEF
) (
    input  logic [3:0]       dec_i,
    input  logic [3:0]       uni_i,
    output logic [ANCHO-1:0] bin_o
);

    logic [ANCHO-1:0] dec_ext;
    logic [ANCHO-1:0] uni_ext;

    assign dec_ext = ANCHO'(dec_i);
    assign uni_ext = ANCHO'(uni_i);

    // tens*10 as (d<<3)+(d<<1); digits are 0..9 so 7 bits never overflow
    assign bin_o = (dec_ext << 3) + (dec_ext << 1) + uni_ext;

endmodule

// File: rtl/control_captura_operandos.sv
// Keypad capture of two 2-digit decimal operands and start/done handshake
// with the arithmetic unit.
//
//   state     | meaning
//   CAP_DEC   | no digit entered yet for the current operand
//   CAP_UNI   | one digit entered (shown as units, tens = 0)
//   CAP_LLENO | two digits entered; further digits ignored
//   ESPERA_OP | operation launched, waiting for op_done or timeout
module control_captura_operandos
    import control_captura_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int ANCHO_NUM      = ANCHO_NUM_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tecla_valida,
    input  logic [3:0]           tecla_codigo,
    input  logic                 op_done,
    output logic [ANCHO_NUM-1:0] op_a,
    output logic [ANCHO_NUM-1:0] op_b,
    output logic                 op_start,
    output logic [3:0]           dig_dec,
    output logic [3:0]           dig_uni,
    output logic                 sel_op,
    output logic                 ocupado,
    output logic                 error
);

    localparam int CNT_W = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(TIMEOUT_CICLOS - 1);

    logic [1:0]           rst_sinc_q;
    logic                 rst_int_n;
    estado_t              estado_q, estado_d;
    logic [3:0]           dec_q, dec_d, uni_q, uni_d;
    logic [ANCHO_NUM-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic                 sel_q, sel_d;
    logic                 start_q, start_d;
    logic                 error_q, error_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ANCHO_NUM-1:0] valor_bin;
    logic                 es_digito;

    bcd2_a_bin #(.ANCHO(ANCHO_NUM)) u_conv (
        .dec_i (dec_q),
        .uni_i (uni_q),
        .bin_o (valor_bin)
    );

    assign es_digito = (tecla_codigo <= 4'd9);
    assign rst_int_n = rst_sinc_q[1];

    // Reset synchronizer: assertion passes straight through, release is delayed two clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sinc_q <= 2'b00;
        else        rst_sinc_q <= {rst_sinc_q[0], 1'b1};
    end

    // Next-state logic: key decoding, operand conversion and wait timeout
    always_comb begin
        estado_d = estado_q;
        dec_d    = dec_q;
        uni_d    = uni_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sel_d    = sel_q;
        start_d  = 1'b0;
        error_d  = error_q;
        cnt_d    = cnt_q;

        if (tecla_valida && tecla_codigo == TECLA_CLR) begin
            // clear wins over everything, including a coincident op_done
            estado_d = CAP_DEC;
            dec_d    = 4'd0;
            uni_d    = 4'd0;
            sel_d    = 1'b0;
            error_d  = 1'b0;
            cnt_d    = '0;
        end else begin
            case (estado_q)
                CAP_DEC: begin
                    if (tecla_valida && es_digito) begin
                        dec_d    = 4'd0;
                        uni_d    = tecla_codigo;
                        estado_d = CAP_UNI;
                    end
                end
                CAP_UNI, CAP_LLENO: begin
                    if (tecla_valida) begin
                        if (es_digito) begin
                            if (estado_q == CAP_UNI) begin
                                dec_d    = uni_q;
                                uni_d    = tecla_codigo;
                                estado_d = CAP_LLENO;
                            end
                        end else if (tecla_codigo == TECLA_SIG && !sel_q) begin
                            op_a_d   = valor_bin;
                            sel_d    = 1'b1;
                            dec_d    = 4'd0;
                            uni_d    = 4'd0;
                            estado_d = CAP_DEC;
                        end else if (tecla_codigo == TECLA_ENTER && sel_q) begin
                            op_b_d   = valor_bin;
                            start_d  = 1'b1;
                            cnt_d    = '0;
                            estado_d = ESPERA_OP;
                        end
                    end
                end
                ESPERA_OP: begin
                    if (op_done || cnt_q == CNT_ULTIMO) begin
                        // op_done takes priority over a timeout in the same cycle
                        error_d  = !op_done;
                        estado_d = CAP_DEC;
                        sel_d    = 1'b0;
                        dec_d    = 4'd0;
                        uni_d    = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: estado_d = CAP_DEC;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            estado_q <= CAP_DEC;
            dec_q    <= 4'd0;
            uni_q    <= 4'd0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sel_q    <= 1'b0;
            start_q  <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            dec_q    <= dec_d;
            uni_q    <= uni_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sel_q    <= sel_d;
            start_q  <= start_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_start = start_q;
    assign dig_dec  = dec_q;
    assign dig_uni  = uni_q;
    assign sel_op   = sel_q;
    assign ocupado  = (estado_q == ESPERA_OP);
    assign error    = error_q;

endmodule

// File: tb/tb_control_captura_operandos.sv
// Bench for control_captura_operandos: directed key sequences, scoreboard of
// expected operands checked whenever op_start is seen.
module tb_control_captura_operandos;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tecla_valida = 1'b0;
    logic [3:0] tecla_codigo = 4'h0;
    logic       op_done = 1'b0;
    logic [6:0] op_a, op_b;
    logic       op_start;
    logic [3:0] dig_dec, dig_uni;
    logic       sel_op, ocupado, error;

    int checks = 0;
    int failures = 0;
    int q_a[$];
    int q_b[$];
    bit chk_low = 1'b0;

    control_captura_operandos #(.TIMEOUT_CICLOS(T), .ANCHO_NUM(7)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tecla_valida (tecla_valida),
        .tecla_codigo (tecla_codigo),
        .op_done      (op_done),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_start     (op_start),
        .dig_dec      (dig_dec),
        .dig_uni      (dig_uni),
        .sel_op       (sel_op),
        .ocupado      (ocupado),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nombre, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nombre, act, exp);
        end
    endtask

    task automatic tecla(input logic [3:0] c);
        @(negedge clk);
        tecla_valida = 1'b1;
        tecla_codigo = c;
        @(negedge clk);
        tecla_valida = 1'b0;
    endtask

    task automatic esperar_inicio(input int a, input int b);
        q_a.push_back(a);
        q_b.push_back(b);
    endtask

    task automatic fin_op(input int espera);
        repeat (espera) @(negedge clk);
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
    endtask

    // Monitor: every op_start pulse must match the next expected operand pair
    always @(negedge clk) begin
        if (chk_low) begin
            chk("start_width", int'(op_start), 0);
            chk_low = 1'b0;
        end
        if (op_start === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_start: got op_start=1 op_a=%0d op_b=%0d expected no start", op_a, op_b);
            end else begin
                chk("start_op_a", int'(op_a), q_a.pop_front());
                chk("start_op_b", int'(op_b), q_b.pop_front());
            end
            chk_low = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_op_a", int'(op_a), 0);
        chk("rst_op_b", int'(op_b), 0);
        chk("rst_start", int'(op_start), 0);
        chk("rst_digits", int'({dig_dec, dig_uni}), 0);
        chk("rst_sel_ocup_err", int'({sel_op, ocupado, error}), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 4,2,A,1,7,E
        tecla(4'd4); tecla(4'd2);
        chk("t1_dec", int'(dig_dec), 4);
        chk("t1_uni", int'(dig_uni), 2);
        tecla(4'hA);
        chk("t1_op_a", int'(op_a), 42);
        chk("t1_sel_after_A", int'(sel_op), 1);
        chk("t1_digits_cleared", int'({dig_dec, dig_uni}), 0);
        tecla(4'd1); tecla(4'd7);
        chk("t1_sel_before_E", int'(sel_op), 1);
        esperar_inicio(42, 17);
        tecla(4'hE);
        chk("t1_ocupado", int'(ocupado), 1);
        fin_op(5);
        chk("t1_done_ocupado", int'(ocupado), 0);
        chk("t1_done_sel", int'(sel_op), 0);
        chk("t1_done_digits", int'({dig_dec, dig_uni}), 0);
        chk("t1_hold_a", int'(op_a), 42);
        chk("t1_hold_b", int'(op_b), 17);

        // 9,A,5,E single digits
        tecla(4'd9);
        chk("t2_single_digit", int'({dig_dec, dig_uni}), 9);
        tecla(4'hA); tecla(4'd5);
        esperar_inicio(9, 5);
        tecla(4'hE);
        fin_op(3);

        // 1,2,3,A,9,9,E third digit ignored
        tecla(4'd1); tecla(4'd2); tecla(4'd3);
        chk("t3_dec", int'(dig_dec), 1);
        chk("t3_uni", int'(dig_uni), 2);
        tecla(4'hA); tecla(4'd9); tecla(4'd9);
        esperar_inicio(12, 99);
        tecla(4'hE);
        fin_op(2);

        // E / A with no digits, then 8,A,E, then 3,E
        tecla(4'hE); tecla(4'hA);
        chk("t4_empty_sel", int'(sel_op), 0);
        chk("t4_empty_ocupado", int'(ocupado), 0);
        tecla(4'hB); tecla(4'hD); tecla(4'hF);
        chk("t4_unused_digits", int'({dig_dec, dig_uni}), 0);
        tecla(4'd8); tecla(4'hA);
        chk("t4_op_a", int'(op_a), 8);
        tecla(4'hE);
        chk("t4_enter_nodig_ocupado", int'(ocupado), 0);
        tecla(4'd3);
        esperar_inicio(8, 3);
        tecla(4'hE);
        fin_op(1);

        // timeout
        tecla(4'd5); tecla(4'hA); tecla(4'd6);
        esperar_inicio(5, 6);
        tecla(4'hE);
        repeat (T - 1) @(negedge clk);
        chk("t5_pre_timeout_ocupado", int'(ocupado), 1);
        chk("t5_pre_timeout_error", int'(error), 0);
        @(negedge clk);
        chk("t5_timeout_error", int'(error), 1);
        chk("t5_timeout_ocupado", int'(ocupado), 0);
        chk("t5_timeout_sel", int'(sel_op), 0);
        tecla(4'hC);
        chk("t5_clear_error", int'(error), 0);

        // op_done on the last timeout cycle
        tecla(4'd5); tecla(4'hA); tecla(4'd6);
        esperar_inicio(5, 6);
        tecla(4'hE);
        repeat (T - 1) @(negedge clk);
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        chk("t5_coincide_error", int'(error), 0);
        chk("t5_coincide_ocupado", int'(ocupado), 0);

        // clear while waiting
        tecla(4'd1); tecla(4'hA); tecla(4'd2);
        esperar_inicio(1, 2);
        tecla(4'hE);
        tecla(4'hC);
        chk("t6_clear_ocupado", int'(ocupado), 0);
        chk("t6_clear_sel", int'(sel_op), 0);
        chk("t6_clear_keeps_a", int'(op_a), 1);

        // async reset in the middle of ESPERA_OP
        tecla(4'd7); tecla(4'hA); tecla(4'd8);
        esperar_inicio(7, 8);
        tecla(4'hE);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t7_rst_op_a", int'(op_a), 0);
        chk("t7_rst_op_b", int'(op_b), 0);
        chk("t7_rst_ocupado", int'(ocupado), 0);
        chk("t7_rst_sel_start", int'({sel_op, op_start}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fin_op(3);
        chk("t7_late_done_ocupado", int'(ocupado), 0);
        chk("t7_late_done_op_a", int'(op_a), 0);
        chk("t7_late_done_error", int'(error), 0);

        repeat (2) @(negedge clk);
        chk("pending_starts", q_a.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_captura_operandos.md
Name: control_captura_operandos

Overview:
- Sequences two-digit decimal keypad entry for two operands.
- Converts each entered tens/units digit pair to a 7-bit binary value (tens*10 + units).
- Hands both operands to the downstream arithmetic unit with a start/done handshake.
- Sits between the keypad decoder and the operation unit; drives the display with the digits currently being entered.

Parameters:
- TIMEOUT_CICLOS, 1000, max cycles to wait for done after start; exceeding it sets the error flag.
- ANCHO_NUM, 7, width of a converted operand (holds 0..99).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- tecla_valida  input  1  one-cycle pulse: tecla_codigo is valid
- tecla_codigo  input  4  0-9 digit; 4'hA next operand; 4'hE enter; 4'hC clear
- op_done  input  1  operation unit finished; level or pulse, sampled only in ESPERA_OP
- op_a  output  ANCHO_NUM  first operand, binary
- op_b  output  ANCHO_NUM  second operand, binary
- op_start  output  1  one-cycle pulse launching the operation
- dig_dec  output  4  tens digit of the operand being entered
- dig_uni  output  4  units digit of the operand being entered
- sel_op  output  1  0 = entering A, 1 = entering B
- ocupado  output  1  high in ESPERA_OP
- error  output  1  sticky timeout flag; cleared by clear key or reset

Behaviour:
- Reset: async assert, sync-released by the design. All outputs 0; state = CAP_DEC.
- Display digit registers:
  - Digit key in CAP_DEC: dig_uni <= key, dig_dec <= 0, state -> CAP_UNI.
  - Digit key in CAP_UNI: dig_dec <= dig_uni, dig_uni <= key, state -> CAP_LLENO (shift entry; second digit becomes units).
  - Digit key in CAP_LLENO: ignored; no overflow past two digits.
- States: CAP_DEC, CAP_UNI, CAP_LLENO, ESPERA_OP.
- 4'hA (next operand) in CAP_UNI or CAP_LLENO with sel_op = 0:
  - op_a <= dig_dec*10 + dig_uni.
  - sel_op <= 1; digits cleared; state -> CAP_DEC.
- 4'hA with sel_op = 1, or in CAP_DEC: ignored.
- 4'hE (enter) in CAP_UNI or CAP_LLENO with sel_op = 1:
  - op_b <= dig_dec*10 + dig_uni.
  - op_start = 1 for exactly the next cycle; state -> ESPERA_OP; timeout counter cleared.
- 4'hE with sel_op = 0, or with no digit entered: ignored.
- A single digit entered gives dec = 0; "7" yields 7.
- ESPERA_OP:
  - All keys ignored except 4'hC.
  - op_done = 1 -> state CAP_DEC, sel_op <= 0, digits cleared; op_a/op_b hold for the display/result path.
  - Counter reaches TIMEOUT_CICLOS-1 without op_done -> error <= 1, state CAP_DEC, sel_op <= 0.
- 4'hC (clear) in any state: digits, sel_op, error, counter cleared; state -> CAP_DEC; op_a/op_b unchanged; no op_start.
- Simultaneous events:
  - op_done and timeout expiry in the same cycle: op_done wins, error stays 0.
  - op_done and 4'hC in the same cycle: clear wins; resulting state is identical.
- Unused codes (B, D, F): ignored in all states.
- Arithmetic: tens*10 computed as (d<<3)+(d<<1) in 7 bits; inputs are restricted to 0-9, so no overflow.
- tecla_valida held high several cycles is treated as multiple keys; the debounce/edge stage is upstream.
- Reset mid-ESPERA_OP: everything to reset values; late op_done after reset is ignored because the state is not ESPERA_OP.

Decomposition:
- Package control_captura_pkg:
  - state enum.
  - Key code constants TECLA_SIG = 4'hA, TECLA_ENTER = 4'hE, TECLA_CLR = 4'hC.
  - ANCHO_NUM default.
- One sub-module: bcd2_a_bin, combinational (dec, uni) -> 7-bit binary, instantiated once on dig_dec/dig_uni.

Test Plan:
- Keys 4,2,A,1,7,E:
  - op_a = 42, op_b = 17.
  - op_start pulses one cycle after E, sel_op = 1 before E; op_done after 5 cycles returns to CAP_DEC.
- Keys 9,A,5,E:
  - op_a = 9, op_b = 5 (single-digit entry, dec = 0).
- Keys 1,2,3,A,9,9,E:
  - third digit ignored; op_a = 12, op_b = 99.
- E with no digits, A with no digits:
  - no state change, no op_start.
  - Then 8,A,E: no start. Then 3,E: start with op_b = 3.
- Start, withhold op_done for TIMEOUT_CICLOS cycles:
  - error = 1, state CAP_DEC.
  - 4'hC clears error. op_done coincident with last timeout cycle leaves error = 0.
- rst_n asserted mid-ESPERA_OP, asynchronously between edges:
  - outputs 0 immediately.
  - op_done pulse after release is ignored; op_a = 0.
